even_parity_generator: RTL and testbench



---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_tree.sv | 33 +++
 rtl/even_parity_generator.sv | 91 +++++++++
 tb/tb_even_parity_generator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants and a reference even-parity helper for the parity generator/checker.
// Pure declarations: no latency, no flow control.
package parity_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

  function automatic logic even_parity(input logic [DEF_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Balanced XOR reduction of a WIDTH-bit word; result is the even-parity bit.
// Combinational, zero latency, no flow control.
module parity_tree
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned LEAVES = 1 << LEVELS;

  // Heap layout: node 0 is the root, children of k are 2k+1 and 2k+2,
  // leaves occupy LEAVES-1 .. 2*LEAVES-2 and are zero-padded past WIDTH.
  logic [2*LEAVES-2:0] node;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < WIDTH) begin : g_data
      assign node[LEAVES-1+i] = data_i[i];
    end else begin : g_pad
      assign node[LEAVES-1+i] = 1'b0;
    end
  end

  for (genvar k = 0; k < LEAVES - 1; k++) begin : g_inner
    assign node[k] = node[2*k+1] ^ node[2*k+2];
  end

  assign parity_o = node[0];

endmodule

// File: rtl/even_parity_generator.sv
// Even-parity generator (combinational + 1-cycle registered copy) with RX parity check and saturating error count.
// RX flag/count update 1 cycle after the sampling edge; no backpressure, a word may be presented every cycle.
module even_parity_generator
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             parity,
  output logic             parity_q,
  output logic [WIDTH-1:0] data_q,
  output logic             out_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_parity,
  input  logic             rx_valid,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  logic             tx_par;
  logic             rx_par;
  logic             rx_bad;

  logic [WIDTH-1:0] tx_data_d, tx_data_q;
  logic             tx_par_d, tx_par_q;
  logic             tx_vld_d, tx_vld_q;
  logic             rx_err_d, rx_err_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

  parity_tree #(.WIDTH(WIDTH)) u_tx_tree (
    .data_i   (data_in),
    .parity_o (tx_par)
  );

  parity_tree #(.WIDTH(WIDTH)) u_rx_tree (
    .data_i   (rx_data),
    .parity_o (rx_par)
  );

  assign rx_bad = rx_valid & (rx_par ^ rx_parity);

  always_comb begin
    tx_data_d = tx_data_q;
    tx_par_d  = tx_par_q;
    tx_vld_d  = in_valid;
    if (in_valid) begin
      tx_data_d = data_in;
      tx_par_d  = tx_par;
    end
  end

  // Clear wins over a simultaneous error, so that error is never counted.
  always_comb begin
    rx_err_d  = rx_bad;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (rx_bad && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
      tx_par_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_par_q  <= tx_par_d;
      tx_vld_q  <= tx_vld_d;
      rx_err_q  <= rx_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign parity     = tx_par;
  assign data_q     = tx_data_q;
  assign parity_q   = tx_par_q;
  assign out_valid  = tx_vld_q;
  assign parity_err = rx_err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_even_parity_generator.sv
// Directed bench for even_parity_generator (WIDTH=8, CNT_W=2).
module tb_even_parity_generator;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       in_valid;
  logic       parity;
  logic       parity_q;
  logic [7:0] data_q;
  logic       out_valid;
  logic [7:0] rx_data;
  logic       rx_parity;
  logic       rx_valid;
  logic       parity_err;
  logic [1:0] err_count;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  even_parity_generator #(.WIDTH(8), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .parity     (parity),
    .parity_q   (parity_q),
    .data_q     (data_q),
    .out_valid  (out_valid),
    .rx_data    (rx_data),
    .rx_parity  (rx_parity),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_cnt;

    rst_n     = 1'b0;
    data_in   = 8'h00;
    in_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_parity = 1'b0;
    rx_valid  = 1'b0;
    err_clr   = 1'b0;

    vecs[0] = '{8'h00, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h02, 1'b1};
    vecs[3] = '{8'hA6, 1'b0};
    vecs[4] = '{8'h0E, 1'b1};
    vecs[5] = '{8'hD9, 1'b1};
    vecs[6] = '{8'hE8, 1'b0};

    #1;
    chk("rst_data_q", 32'(data_q), 32'h0);
    chk("rst_parity_q", 32'(parity_q), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);

    // Combinational sweep while held in reset: registers cannot move.
    for (int i = 0; i < 7; i++) begin
      data_in = vecs[i].data;
      #1;
      chk($sformatf("comb_parity_%02h", vecs[i].data), 32'(parity), 32'(vecs[i].exp_par));
    end

    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    data_in  = 8'hD9;
    in_valid = 1'b1;
    step();
    chk("tx_data_q", 32'(data_q), 32'hD9);
    chk("tx_parity_q", 32'(parity_q), 32'h1);
    chk("tx_out_valid", 32'(out_valid), 32'h1);

    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 8'h00;
    step();
    chk("hold_out_valid", 32'(out_valid), 32'h0);
    chk("hold_data_q", 32'(data_q), 32'hD9);
    chk("hold_parity_q", 32'(parity_q), 32'h1);

    @(negedge clk);
    rx_data   = 8'hA6;
    rx_parity = 1'b0;
    rx_valid  = 1'b1;
    step();
    chk("rx_good_err", 32'(parity_err), 32'h0);
    chk("rx_good_cnt", 32'(err_count), 32'h0);

    @(negedge clk);
    rx_parity = 1'b1;
    step();
    chk("rx_bad_err", 32'(parity_err), 32'h1);
    chk("rx_bad_cnt", 32'(err_count), 32'h1);

    exp_cnt = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_data   = 8'h01 << i;
      rx_parity = 1'b0;
      step();
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      chk($sformatf("sat_err_%0d", i), 32'(parity_err), 32'h1);
      chk($sformatf("sat_cnt_%0d", i), 32'(err_count), 32'(exp_cnt));
    end

    @(negedge clk);
    rx_data   = 8'h0E;
    rx_parity = 1'b0;
    err_clr   = 1'b1;
    step();
    chk("clr_err", 32'(parity_err), 32'h1);
    chk("clr_cnt", 32'(err_count), 32'h0);

    @(negedge clk);
    err_clr  = 1'b0;
    rx_valid = 1'b0;
    step();
    chk("idle_err", 32'(parity_err), 32'h0);
    chk("idle_cnt", 32'(err_count), 32'h0);

    // Bad parity without rx_valid must be ignored.
    @(negedge clk);
    rx_data   = 8'hE8;
    rx_parity = 1'b1;
    step();
    chk("novld_err", 32'(parity_err), 32'h0);
    chk("novld_cnt", 32'(err_count), 32'h0);

    @(negedge clk);
    rx_valid = 1'b1;
    step();
    @(negedge clk);
    data_in  = 8'hA5;
    in_valid = 1'b1;
    step();
    chk("pre_rst_cnt", 32'(err_count), 32'h2);
    chk("pre_rst_err", 32'(parity_err), 32'h1);
    chk("pre_rst_vld", 32'(out_valid), 32'h1);
    chk("pre_rst_data", 32'(data_q), 32'hA5);

    #1;
    rst_n   = 1'b0;
    data_in = 8'h07;
    #1;
    chk("arst_data_q", 32'(data_q), 32'h0);
    chk("arst_parity_q", 32'(parity_q), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_parity_err", 32'(parity_err), 32'h0);
    chk("arst_err_count", 32'(err_count), 32'h0);
    chk("arst_parity_07", 32'(parity), 32'h1);
    data_in = 8'h03;
    #1;
    chk("arst_parity_03", 32'(parity), 32'h0);

    step();
    chk("in_rst_out_valid", 32'(out_valid), 32'h0);
    chk("in_rst_err_count", 32'(err_count), 32'h0);

    @(negedge clk);
    in_valid = 1'b0;
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_parity_err", 32'(parity_err), 32'h0);

    for (int v = 0; v < 256; v++) begin
      data_in = 8'(v);
      #1;
      chk($sformatf("exh_even_%02h", v), 32'(($countones(data_in) + int'(parity)) % 2), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
